// File: rtl/mor1kx_decode_buffered_if.sv
// mor1kx_decode_buffered_if
//   Bundles the fetch-side offer, the execute-side handshake, the flush
//   strobe and the registered decode results of mor1kx_decode_buffered.
//   slave  : the decode buffer (consumes fetch/flush/exec_ready, drives results)
//   master : the surrounding pipeline (fetch + execute + control)
// Parameters
//   OW : operand / pc / immediate width
//   RW : GPR address width
interface mor1kx_decode_buffered_if #(
  parameter int OW = 32,
  parameter int RW = 5
);
  // fetch side
  logic          fetch_valid;
  logic [31:0]   fetch_insn;
  logic [OW-1:0] fetch_pc;
  logic          decode_ready;
  // control
  logic          flush;
  // execute side
  logic          exec_ready;
  logic          decode_valid;
  logic [OW-1:0] decode_pc;
  logic [5:0]    decode_opc_insn;
  logic [RW-1:0] decode_rfa_adr;
  logic [RW-1:0] decode_rfb_adr;
  logic [RW-1:0] decode_rfd_adr;
  logic [OW-1:0] decode_immediate;
  logic          decode_immediate_sel;
  logic          decode_rf_wb;
  logic          decode_op_branch;
  logic          decode_op_lsu_load;
  logic          decode_op_lsu_store;
  logic [1:0]    decode_lsu_length;
  logic          decode_delay_slot;
  logic          decode_except_illegal;
  logic          decode_except_syscall;
  logic          decode_except_trap;
  logic          decode_except_ibus_align;

  modport slave (
    input  fetch_valid, fetch_insn, fetch_pc, flush, exec_ready,
    output decode_ready, decode_valid, decode_pc, decode_opc_insn,
           decode_rfa_adr, decode_rfb_adr, decode_rfd_adr,
           decode_immediate, decode_immediate_sel, decode_rf_wb,
           decode_op_branch, decode_op_lsu_load, decode_op_lsu_store,
           decode_lsu_length, decode_delay_slot, decode_except_illegal,
           decode_except_syscall, decode_except_trap, decode_except_ibus_align
  );

  modport master (
    output fetch_valid, fetch_insn, fetch_pc, flush, exec_ready,
    input  decode_ready, decode_valid, decode_pc, decode_opc_insn,
           decode_rfa_adr, decode_rfb_adr, decode_rfd_adr,
           decode_immediate, decode_immediate_sel, decode_rf_wb,
           decode_op_branch, decode_op_lsu_load, decode_op_lsu_store,
           decode_lsu_length, decode_delay_slot, decode_except_illegal,
           decode_except_syscall, decode_except_trap, decode_except_ibus_align
  );
endinterface

// File: rtl/mor1kx_decode_buffered.sv
// mor1kx_decode_buffered
//   Buffered OR1K decode stage between fetch and execute. Fetched {insn,pc}
//   pairs go into a small FIFO; the head entry is decoded combinationally and
//   captured into an output register presented to execute under valid/ready.
//   Tracks delay slots and stops issuing after an excepting insn until flush.
// Ports
//   clk : clock
//   rst : synchronous active-high reset (same effect as flush, plus clears
//         the registered decode fields)
//   dif : mor1kx_decode_buffered_if.slave -- fetch offer/ready, flush,
//         exec_ready and all registered decode outputs
module mor1kx_decode_buffered #(
  parameter int    OPTION_OPERAND_WIDTH    = 32,
  parameter int    OPTION_RF_ADDR_WIDTH    = 5,
  parameter int    OPTION_DECODE_BUF_DEPTH = 4,
  parameter string FEATURE_MULTIPLIER      = "PARALLEL",
  parameter string FEATURE_DIVIDER         = "NONE",
  parameter string FEATURE_ADDC            = "NONE",
  parameter string FEATURE_SYSCALL         = "ENABLED",
  parameter string FEATURE_TRAP            = "ENABLED",
  parameter string FEATURE_CUST1           = "NONE",
  parameter string FEATURE_CUST2           = "NONE",
  parameter string FEATURE_CUST3           = "NONE",
  parameter string FEATURE_CUST4           = "NONE",
  parameter string FEATURE_CUST5           = "NONE",
  parameter string FEATURE_CUST6           = "NONE",
  parameter string FEATURE_CUST7           = "NONE",
  parameter string FEATURE_CUST8           = "NONE"
) (
  input  logic                       clk,
  input  logic                       rst,
  mor1kx_decode_buffered_if.slave    dif
);

  localparam int OW    = OPTION_OPERAND_WIDTH;
  localparam int RW    = OPTION_RF_ADDR_WIDTH;
  localparam int DEPTH = OPTION_DECODE_BUF_DEPTH;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  localparam bit HAS_MUL  = (FEATURE_MULTIPLIER != "NONE");
  localparam bit HAS_DIV  = (FEATURE_DIVIDER != "NONE");
  localparam bit HAS_ADDC = (FEATURE_ADDC != "NONE");
  localparam bit HAS_SYS  = (FEATURE_SYSCALL == "ENABLED");
  localparam bit HAS_TRAP = (FEATURE_TRAP == "ENABLED");
  localparam bit HAS_C1   = (FEATURE_CUST1 != "NONE");
  localparam bit HAS_C2   = (FEATURE_CUST2 != "NONE");
  localparam bit HAS_C3   = (FEATURE_CUST3 != "NONE");
  localparam bit HAS_C4   = (FEATURE_CUST4 != "NONE");
  localparam bit HAS_C5   = (FEATURE_CUST5 != "NONE");
  localparam bit HAS_C6   = (FEATURE_CUST6 != "NONE");
  localparam bit HAS_C7   = (FEATURE_CUST7 != "NONE");
  localparam bit HAS_C8   = (FEATURE_CUST8 != "NONE");

  // major opcodes (insn[31:26])
  localparam logic [5:0] OPC_J      = 6'h00, OPC_JAL   = 6'h01, OPC_BNF  = 6'h03,
                         OPC_BF     = 6'h04, OPC_NOP   = 6'h05, OPC_MOVHI = 6'h06,
                         OPC_SYSTRP = 6'h08, OPC_RFE   = 6'h09, OPC_JR   = 6'h11,
                         OPC_JALR   = 6'h12, OPC_CUST1 = 6'h1c, OPC_CUST2 = 6'h1d,
                         OPC_CUST3  = 6'h1e, OPC_CUST4 = 6'h1f, OPC_LWZ  = 6'h21,
                         OPC_LWS    = 6'h22, OPC_LBZ   = 6'h23, OPC_LBS  = 6'h24,
                         OPC_LHZ    = 6'h25, OPC_LHS   = 6'h26, OPC_ADDI = 6'h27,
                         OPC_ADDIC  = 6'h28, OPC_ANDI  = 6'h29, OPC_ORI  = 6'h2a,
                         OPC_XORI   = 6'h2b, OPC_MULI  = 6'h2c, OPC_MFSPR = 6'h2d,
                         OPC_SHRTI  = 6'h2e, OPC_SFI   = 6'h2f, OPC_MTSPR = 6'h30,
                         OPC_SW     = 6'h35, OPC_SB    = 6'h36, OPC_SH   = 6'h37,
                         OPC_ALU    = 6'h38, OPC_SF    = 6'h39, OPC_CUST5 = 6'h3c,
                         OPC_CUST6  = 6'h3d, OPC_CUST7 = 6'h3e, OPC_CUST8 = 6'h3f;

  typedef struct packed {
    logic [OW-1:0] pc;
    logic [5:0]    opc;
    logic [RW-1:0] rfa;
    logic [RW-1:0] rfb;
    logic [RW-1:0] rfd;
    logic [OW-1:0] imm;
    logic          imm_sel;
    logic          rf_wb;
    logic          branch;
    logic          load;
    logic          store;
    logic [1:0]    lsu_len;
    logic          dslot;
    logic          illegal;
    logic          syscall;
    logic          trap;
    logic          ibus_align;
  } dec_t;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------- FIFO
  logic [31:0]   mem_insn [DEPTH];
  logic [OW-1:0] mem_pc   [DEPTH];
  logic [AW:0]   wp, rp;
  logic          empty, full, push, pop, ready, load;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  // Flush wins over any fetch offer in the same cycle.
  assign push  = dif.fetch_valid && ready && !dif.flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_insn[wp[AW-1:0]] <= dif.fetch_insn;
      mem_pc[wp[AW-1:0]]   <= dif.fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || dif.flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + PTR_ONE;
      if (pop)  rp <= rp + PTR_ONE;
    end
  end

  // ---------------------------------------------------------- output reg
  dec_t out_q, dec;
  logic vld_q, track_q, track_nxt, consume, dec_except;

  assign load    = !vld_q || dif.exec_ready;
  assign consume = vld_q && dif.exec_ready;
  // The tracker must reflect a branch consumed in this very cycle, so the
  // delay-slot insn loaded alongside it is marked without a bubble.
  assign track_nxt = consume ? out_q.branch : track_q;

  // --------------------------------------------------------- head decode
  logic [31:0]   insn;
  logic [OW-1:0] head_pc;
  logic [5:0]    opc;
  logic [OW-1:0] imm_sext, imm_zext, imm_high, imm_jump, imm_shift;
  logic [OW-1:0] imm_st_sext, imm_st_zext;
  logic          sf_ok, legal;

  assign insn    = mem_insn[rp[AW-1:0]];
  assign head_pc = mem_pc[rp[AW-1:0]];
  assign opc     = insn[31:26];

  assign imm_sext    = {{(OW-16){insn[15]}}, insn[15:0]};
  assign imm_zext    = OW'(insn[15:0]);
  assign imm_high    = OW'({insn[15:0], 16'h0000});
  assign imm_jump    = {{(OW-26){insn[25]}}, insn[25:0]};
  assign imm_shift   = OW'(insn[5:0]);
  // store / mtspr split immediate: {insn[25:21], insn[10:0]}
  assign imm_st_sext = {{(OW-16){insn[25]}}, insn[25:21], insn[10:0]};
  assign imm_st_zext = OW'({insn[25:21], insn[10:0]});

  // set-flag compare codes: eq,ne,gtu,geu,ltu,leu and gts,ges,lts,les
  assign sf_ok = (insn[25:21] <= 5'h05) ||
                 ((insn[25:21] >= 5'h0a) && (insn[25:21] <= 5'h0d));

  always_comb begin
    dec            = '0;
    legal          = 1'b1;
    dec.pc         = head_pc;
    dec.opc        = opc;
    dec.rfa        = RW'(insn[20:16]);
    dec.rfb        = RW'(insn[15:11]);
    dec.rfd        = RW'(insn[25:21]);
    dec.lsu_len    = 2'b10;
    dec.dslot      = track_nxt;
    dec.ibus_align = (head_pc[1:0] != 2'b00);
    case (opc)
      OPC_J, OPC_BNF, OPC_BF: begin
        dec.branch = 1'b1;
        dec.imm    = imm_jump;
      end
      OPC_JAL: begin
        dec.branch = 1'b1;
        dec.rf_wb  = 1'b1;
        dec.rfd    = RW'(9);
        dec.imm    = imm_jump;
      end
      OPC_JR:   dec.branch = 1'b1;
      OPC_JALR: begin
        dec.branch = 1'b1;
        dec.rf_wb  = 1'b1;
        dec.rfd    = RW'(9);
      end
      OPC_NOP, OPC_RFE: ;
      OPC_MOVHI: begin
        // insn[16]=1 is l.macrc, which needs a MAC unit this core lacks
        legal       = !insn[16];
        dec.rf_wb   = 1'b1;
        dec.imm_sel = 1'b1;
        dec.imm     = imm_high;
      end
      OPC_SYSTRP: begin
        case (insn[25:16])
          10'h000: begin legal = HAS_SYS;  dec.syscall = HAS_SYS;  end
          10'h100: begin legal = HAS_TRAP; dec.trap    = HAS_TRAP; end
          10'h200, 10'h280, 10'h300: ;  // msync / psync / csync
          default: legal = 1'b0;
        endcase
      end
      OPC_LWZ, OPC_LWS, OPC_LBZ, OPC_LBS, OPC_LHZ, OPC_LHS: begin
        dec.load    = 1'b1;
        dec.rf_wb   = 1'b1;
        dec.imm_sel = 1'b1;
        dec.imm     = imm_sext;
        if (opc == OPC_LBZ || opc == OPC_LBS)      dec.lsu_len = 2'b00;
        else if (opc == OPC_LHZ || opc == OPC_LHS) dec.lsu_len = 2'b01;
      end
      OPC_ADDI, OPC_ADDIC, OPC_XORI, OPC_MULI: begin
        dec.rf_wb   = 1'b1;
        dec.imm_sel = 1'b1;
        dec.imm     = imm_sext;
        if (opc == OPC_ADDIC) legal = HAS_ADDC;
        if (opc == OPC_MULI)  legal = HAS_MUL;
      end
      OPC_ANDI, OPC_ORI, OPC_MFSPR: begin
        dec.rf_wb   = 1'b1;
        dec.imm_sel = 1'b1;
        dec.imm     = imm_zext;
      end
      OPC_SHRTI: begin
        // all four shift kinds (sll/srl/sra/ror) accepted
        dec.rf_wb   = 1'b1;
        dec.imm_sel = 1'b1;
        dec.imm     = imm_shift;
      end
      OPC_SFI: begin
        legal       = sf_ok;
        dec.imm_sel = 1'b1;
        dec.imm     = imm_sext;
      end
      // operand B carries the data word; the immediate is an address offset
      OPC_MTSPR: dec.imm = imm_st_zext;
      OPC_SW, OPC_SB, OPC_SH: begin
        dec.store = 1'b1;
        dec.imm   = imm_st_sext;
        if (opc == OPC_SB)      dec.lsu_len = 2'b00;
        else if (opc == OPC_SH) dec.lsu_len = 2'b01;
      end
      OPC_ALU: begin
        dec.rf_wb = 1'b1;
        case (insn[3:0])
          4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'hc, 4'hd, 4'he, 4'hf: ;
          4'h1:       legal = HAS_ADDC;
          4'h6, 4'hb: legal = HAS_MUL;
          4'h9, 4'ha: legal = HAS_DIV;
          default:    legal = 1'b0;   // l.muld and friends
        endcase
      end
      OPC_SF:    legal = sf_ok;
      OPC_CUST1: legal = HAS_C1;
      OPC_CUST2: legal = HAS_C2;
      OPC_CUST3: legal = HAS_C3;
      OPC_CUST4: legal = HAS_C4;
      OPC_CUST5: legal = HAS_C5;
      OPC_CUST6: legal = HAS_C6;
      OPC_CUST7: legal = HAS_C7;
      OPC_CUST8: legal = HAS_C8;
      default:   legal = 1'b0;
    endcase
    // an illegal insn must have no architectural side effects
    if (!legal) begin
      dec.rf_wb  = 1'b0;
      dec.branch = 1'b0;
      dec.load   = 1'b0;
      dec.store  = 1'b0;
    end
    dec.illegal = !legal;
  end

  assign dec_except = dec.illegal || dec.syscall || dec.trap || dec.ibus_align;

  // ------------------------------------------------------------ halt FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    pop       = 1'b0;
    case (state)
      S_RUN: begin
        ready = !full;
        pop   = load && !empty && !dif.flush;
        if (pop && dec_except) state_nxt = S_HALT;
      end
      S_HALT: ;  // no intake, no issue; only flush restarts
      default: state_nxt = S_RUN;
    endcase
    if (dif.flush) state_nxt = S_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q         <= 1'b0;
      track_q       <= 1'b0;
      out_q         <= '0;
      out_q.lsu_len <= 2'b10;
    end else if (dif.flush) begin
      vld_q   <= 1'b0;
      track_q <= 1'b0;
    end else begin
      track_q <= track_nxt;
      if (load) begin
        vld_q <= pop;
        if (pop) out_q <= dec;
      end
    end
  end

  // ------------------------------------------------------------- outputs
  assign dif.decode_ready             = ready;
  assign dif.decode_valid             = vld_q;
  assign dif.decode_pc                = out_q.pc;
  assign dif.decode_opc_insn          = out_q.opc;
  assign dif.decode_rfa_adr           = out_q.rfa;
  assign dif.decode_rfb_adr           = out_q.rfb;
  assign dif.decode_rfd_adr           = out_q.rfd;
  assign dif.decode_immediate         = out_q.imm;
  assign dif.decode_immediate_sel     = out_q.imm_sel;
  assign dif.decode_rf_wb             = out_q.rf_wb;
  assign dif.decode_op_branch         = out_q.branch;
  assign dif.decode_op_lsu_load       = out_q.load;
  assign dif.decode_op_lsu_store      = out_q.store;
  assign dif.decode_lsu_length        = out_q.lsu_len;
  assign dif.decode_delay_slot        = out_q.dslot;
  assign dif.decode_except_illegal    = out_q.illegal;
  assign dif.decode_except_syscall    = out_q.syscall;
  assign dif.decode_except_trap       = out_q.trap;
  assign dif.decode_except_ibus_align = out_q.ibus_align;

endmodule

// File: tb/tb_mor1kx_decode_buffered.sv
// tb_mor1kx_decode_buffered
//   Directed vectors with hand-computed expectations for the buffered
//   decoder (multiplier configured out so l.mul decodes as illegal).
module tb_mor1kx_decode_buffered;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mor1kx_decode_buffered_if #(.OW(32), .RW(5)) dif ();

  mor1kx_decode_buffered #(.FEATURE_MULTIPLIER("NONE")) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  logic [31:0] t2_insn [5];
  logic [31:0] t2_imm  [5];
  logic        t2_ld   [5];
  logic        t2_st   [5];
  logic [1:0]  t2_len  [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] insn, input logic [31:0] pc);
    dif.fetch_valid = 1'b1;
    dif.fetch_insn  = insn;
    dif.fetch_pc    = pc;
    tick();
  endtask

  // single insn into an idle buffer, returns once it is presented
  task automatic present(input logic [31:0] insn, input logic [31:0] pc);
    drive(insn, pc);
    dif.fetch_valid = 1'b0;
    tick();
  endtask

  task automatic flush_pulse();
    dif.flush = 1'b1;
    tick();
    dif.flush = 1'b0;
  endtask

  initial begin
    t2_insn = '{32'h9C210004, 32'hA4648000, 32'h98A6FFFE, 32'hD7E117FC, 32'h18E01234};
    t2_imm  = '{32'h00000004, 32'h00008000, 32'hFFFFFFFE, 32'hFFFFFFFC, 32'h12340000};
    t2_ld   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    t2_st   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    t2_len  = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10};

    rst             = 1'b1;
    dif.flush       = 1'b0;
    dif.exec_ready  = 1'b0;
    dif.fetch_valid = 1'b0;
    dif.fetch_insn  = '0;
    dif.fetch_pc    = '0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_valid", dif.decode_valid, 0);
    check("rst_ready", dif.decode_ready, 1);
    check("rst_len",   dif.decode_lsu_length, 2'b10);
    check("rst_rfd",   dif.decode_rfd_adr, 0);
    check("rst_imm",   dif.decode_immediate, 0);
    check("rst_ds",    dif.decode_delay_slot, 0);

    // 1: l.addi r1,r1,4 appears two cycles after the offer
    dif.exec_ready = 1'b1;
    drive(32'h9C210004, 32'h0000_0000);
    dif.fetch_valid = 1'b0;
    check("t1_early", dif.decode_valid, 0);
    tick();
    check("t1_valid",   dif.decode_valid, 1);
    check("t1_rfd",     dif.decode_rfd_adr, 1);
    check("t1_rfa",     dif.decode_rfa_adr, 1);
    check("t1_imm",     dif.decode_immediate, 32'h4);
    check("t1_imm_sel", dif.decode_immediate_sel, 1);
    check("t1_rf_wb",   dif.decode_rf_wb, 1);
    check("t1_illegal", dif.decode_except_illegal, 0);
    tick();
    check("t1_drain", dif.decode_valid, 0);

    // 2: stall execute, fill FIFO plus output reg, then drain in order
    dif.exec_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("t2_ready", dif.decode_ready, 1);
      drive(t2_insn[k], 32'h100 + 32'(4 * k));
    end
    check("t2_full", dif.decode_ready, 0);
    drive(32'h15000000, 32'h200);  // refused
    dif.fetch_valid = 1'b0;
    check("t2_still_full", dif.decode_ready, 0);
    dif.exec_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("t2_valid", dif.decode_valid, 1);
      check("t2_pc",    dif.decode_pc, 32'h100 + 32'(4 * k));
      check("t2_imm",   dif.decode_immediate, t2_imm[k]);
      check("t2_load",  dif.decode_op_lsu_load, t2_ld[k]);
      check("t2_store", dif.decode_op_lsu_store, t2_st[k]);
      check("t2_len",   dif.decode_lsu_length, t2_len[k]);
      tick();
    end
    check("t2_no_extra", dif.decode_valid, 0);

    // 3: l.j, l.nop (delay slot), l.addi
    drive(32'h00000003, 32'h300);
    drive(32'h15000000, 32'h304);
    check("t3_j_branch", dif.decode_op_branch, 1);
    check("t3_j_imm",    dif.decode_immediate, 32'h3);
    check("t3_j_ds",     dif.decode_delay_slot, 0);
    drive(32'h9C210004, 32'h308);
    dif.fetch_valid = 1'b0;
    check("t3_nop_opc", dif.decode_opc_insn, 6'h05);
    check("t3_nop_ds",  dif.decode_delay_slot, 1);
    tick();
    check("t3_add_pc", dif.decode_pc, 32'h308);
    check("t3_add_ds", dif.decode_delay_slot, 0);
    tick();
    check("t3_drain", dif.decode_valid, 0);

    // 4: disabled custom opcode halts issue until flush
    dif.exec_ready = 1'b0;
    drive(32'hFC000000, 32'h400);
    drive(32'h15000000, 32'h404);
    dif.fetch_valid = 1'b0;
    check("t4_illegal", dif.decode_except_illegal, 1);
    check("t4_halt_rdy", dif.decode_ready, 0);
    dif.exec_ready = 1'b1;
    tick();
    check("t4_consumed", dif.decode_valid, 0);
    check("t4_no_nop",   dif.decode_ready, 0);
    tick();
    check("t4_no_nop2",  dif.decode_valid, 0);
    flush_pulse();
    check("t4_fl_valid", dif.decode_valid, 0);
    check("t4_fl_ready", dif.decode_ready, 1);
    tick();
    tick();
    check("t4_nop_gone", dif.decode_valid, 0);

    // 5: syscall / trap / l.mul without multiplier / shifts / misaligned pc
    dif.exec_ready = 1'b0;
    present(32'h20000000, 32'h500);
    check("t5_sys",      dif.decode_except_syscall, 1);
    check("t5_sys_ill",  dif.decode_except_illegal, 0);
    check("t5_sys_halt", dif.decode_ready, 0);
    flush_pulse();
    present(32'h21000000, 32'h504);
    check("t5_trap", dif.decode_except_trap, 1);
    check("t5_trap_sys", dif.decode_except_syscall, 0);
    flush_pulse();
    present(32'hE0221306, 32'h508);
    check("t5_mul_ill", dif.decode_except_illegal, 1);
    check("t5_mul_wb",  dif.decode_rf_wb, 0);
    flush_pulse();
    present(32'hE0221888, 32'h50C);
    check("t5_sra_ill", dif.decode_except_illegal, 0);
    check("t5_sra_wb",  dif.decode_rf_wb, 1);
    check("t5_sra_rdy", dif.decode_ready, 1);
    flush_pulse();
    present(32'hB82200C5, 32'h510);
    check("t5_rori_ill", dif.decode_except_illegal, 0);
    check("t5_rori_imm", dif.decode_immediate, 32'h5);
    flush_pulse();
    present(32'h15000000, 32'h102);
    check("t5_align", dif.decode_except_ibus_align, 1);
    check("t5_align_halt", dif.decode_ready, 0);
    flush_pulse();

    // 6: flush + rst with full FIFO and a pending offer
    for (int k = 0; k < 5; k++) drive(32'h15000000, 32'h600 + 32'(4 * k));
    check("t6_full", dif.decode_ready, 0);
    dif.fetch_valid = 1'b1;
    dif.fetch_insn  = 32'h9C210004;
    dif.fetch_pc    = 32'h700;
    dif.flush       = 1'b1;
    rst             = 1'b1;
    tick();
    rst             = 1'b0;
    dif.flush       = 1'b0;
    dif.fetch_valid = 1'b0;
    dif.exec_ready  = 1'b1;
    check("t6_valid", dif.decode_valid, 0);
    check("t6_ready", dif.decode_ready, 1);
    check("t6_pc",    dif.decode_pc, 0);
    check("t6_len",   dif.decode_lsu_length, 2'b10);
    check("t6_opc",   dif.decode_opc_insn, 0);
    tick();
    tick();
    check("t6_dropped", dif.decode_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
